branch_predictor: RTL and testbench

- IF-stage next-PC generator. Sits directly downstream of the branch target buffer and owns the fetch PC register.
- Combines the BTB hit, target and type with a gshare pattern history table (PHT) of 2-bit counters to choose the next fetch PC.
- Takes branch/jump resolution from EX. On a mispredict it updates the PHT and global history, asserts flush and redirects fetch.

---
 rtl/bp_pkg.sv | 20 ++
 rtl/sat_counter2.sv | 26 ++
 rtl/branch_predictor.sv | 161 ++++++++++++++++
 tb/tb_branch_predictor.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared definitions for the IF-stage branch predictor: 2-bit counter
// encodings, the PHT reset state and the instruction size used for
// sequential fetch.
package bp_pkg;

    // 2-bit saturating counter states; bit 1 is the taken prediction.
    typedef enum logic [1:0] {
        SNT = 2'b00,  // strongly not-taken
        WNT = 2'b01,  // weakly not-taken
        WT  = 2'b10,  // weakly taken
        ST  = 2'b11   // strongly taken
    } cnt_e;

    // Every PHT counter starts weakly not-taken.
    localparam cnt_e PHT_RESET = WNT;

    // Fixed-width instructions: fall-through PC is PC + INSN_BYTES.
    localparam int unsigned INSN_BYTES = 4;

endpackage : bp_pkg

// File: rtl/sat_counter2.sv
// 2-bit saturating up/down counter next-value function. Moves one step
// toward the resolved outcome and sticks at the rails (11 when taken,
// 00 when not taken).
module sat_counter2
    import bp_pkg::*;
(
    input  logic [1:0] cnt,
    input  logic       taken,
    output logic [1:0] cnt_next
);

    // Step toward the outcome, holding at ST/SNT instead of wrapping.
    always_comb begin
        cnt_next = cnt;
        if (taken) begin
            if (cnt != ST) begin
                cnt_next = cnt + 2'd1;
            end
        end else begin
            if (cnt != SNT) begin
                cnt_next = cnt - 2'd1;
            end
        end
    end

endmodule : sat_counter2

// File: rtl/branch_predictor.sv
// IF-stage next-PC generator. Owns the fetch PC, combines the BTB lookup
// with a gshare PHT of 2-bit counters to predict the next PC, and takes
// resolutions from EX to train the PHT/GHR and redirect on mispredicts.
module branch_predictor
    import bp_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          PHT_ENTRIES = 64,
    parameter int          IDX_WIDTH   = 6,
    parameter int          GHR_WIDTH   = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall,
    // BTB lookup result for IF_pc
    input  logic                 btb_hit,
    input  logic [31:0]          btb_target,
    input  logic                 btb_branch,
    input  logic                 btb_jump,
    // Fetch side
    output logic [31:0]          IF_pc,
    output logic                 IF_pred_taken,
    output logic [31:0]          IF_pred_target,
    output logic [IDX_WIDTH-1:0] IF_pred_idx,
    // Resolution from EX
    input  logic                 EX_valid,
    input  logic                 EX_is_branch,
    input  logic [31:0]          EX_pc,
    input  logic                 EX_taken,
    input  logic [31:0]          EX_target,
    input  logic                 EX_pred_taken,
    input  logic [31:0]          EX_pred_target,
    input  logic [IDX_WIDTH-1:0] EX_pred_idx,
    // Redirect and statistics
    output logic                 flush,
    output logic [31:0]          branch_count,
    output logic [31:0]          mispredict_count
);

    // Saturating increment for the statistics counters.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // State
    logic [31:0]          pc_q, pc_d;
    logic [GHR_WIDTH-1:0] ghr_q, ghr_d;
    logic [1:0]           pht_q [PHT_ENTRIES];
    logic [1:0]           pht_d [PHT_ENTRIES];
    logic [31:0]          branch_count_q, branch_count_d;
    logic [31:0]          mispredict_count_q, mispredict_count_d;

    // Combinational helpers
    logic [IDX_WIDTH-1:0] if_idx;
    logic [1:0]           if_cnt;
    logic [31:0]          pc_plus4;
    logic [31:0]          ex_pc_plus4;
    logic                 pred_taken;
    logic [31:0]          pred_target;
    logic                 mis;
    logic                 flush_w;
    logic                 pht_upd;
    logic [1:0]           upd_cnt;
    logic [1:0]           upd_cnt_next;

    // gshare index: word-aligned PC bits hashed with the committed history.
    assign if_idx      = pc_q[IDX_WIDTH+1:2] ^ IDX_WIDTH'(ghr_q);
    assign if_cnt      = pht_q[if_idx];
    assign pc_plus4    = pc_q + 32'(INSN_BYTES);
    assign ex_pc_plus4 = EX_pc + 32'(INSN_BYTES);

    // Prediction for the current fetch PC; a jump wins over a branch when
    // the BTB entry claims to be both.
    always_comb begin
        pred_taken = 1'b0;
        if (btb_hit) begin
            if (btb_jump) begin
                pred_taken = 1'b1;
            end else if (btb_branch) begin
                pred_taken = if_cnt[1];
            end
        end
        pred_target = pred_taken ? btb_target : pc_plus4;
    end

    // A resolution mispredicts on a wrong direction, or on a correct taken
    // direction with the wrong target. Flush is forced low during reset.
    assign mis     = (EX_taken != EX_pred_taken) ||
                     (EX_taken && (EX_target != EX_pred_target));
    assign flush_w = rst_n && EX_valid && mis;

    // Only conditional branches train the PHT and history.
    assign pht_upd = EX_valid && EX_is_branch;
    assign upd_cnt = pht_q[EX_pred_idx];

    sat_counter2 u_sat_counter2 (
        .cnt      (upd_cnt),
        .taken    (EX_taken),
        .cnt_next (upd_cnt_next)
    );

    // Next fetch PC: redirect beats stall, stall beats prediction.
    always_comb begin
        pc_d = pred_target;
        if (flush_w) begin
            pc_d = EX_taken ? EX_target : ex_pc_plus4;
        end else if (stall) begin
            pc_d = pc_q;
        end
    end

    // Non-speculative PHT/GHR training at branch resolution.
    always_comb begin
        pht_d = pht_q;
        ghr_d = ghr_q;
        if (pht_upd) begin
            pht_d[EX_pred_idx] = upd_cnt_next;
            ghr_d              = GHR_WIDTH'({ghr_q, EX_taken});
        end
    end

    // Saturating statistics counters.
    always_comb begin
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
        if (pht_upd) begin
            branch_count_d = sat_inc32(branch_count_q);
        end
        if (flush_w) begin
            mispredict_count_d = sat_inc32(mispredict_count_q);
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q               <= RESET_PC;
            ghr_q              <= '0;
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
            for (int i = 0; i < PHT_ENTRIES; i++) begin
                pht_q[i] <= PHT_RESET;
            end
        end else begin
            pc_q               <= pc_d;
            ghr_q              <= ghr_d;
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
            pht_q              <= pht_d;
        end
    end

    assign IF_pc            = pc_q;
    assign IF_pred_taken    = pred_taken;
    assign IF_pred_target   = pred_target;
    assign IF_pred_idx      = if_idx;
    assign flush            = flush_w;
    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;

endmodule : branch_predictor

// File: tb/tb_branch_predictor.sv
// Testbench for branch_predictor: directed scenarios followed by random
// traffic, all compared against a behavioural next-PC / gshare model.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        stall = 1'b0;
    logic        btb_hit = 1'b0;
    logic [31:0] btb_target = 32'h0;
    logic        btb_branch = 1'b0;
    logic        btb_jump = 1'b0;
    logic [31:0] IF_pc;
    logic        IF_pred_taken;
    logic [31:0] IF_pred_target;
    logic [5:0]  IF_pred_idx;
    logic        EX_valid = 1'b0;
    logic        EX_is_branch = 1'b0;
    logic [31:0] EX_pc = 32'h0;
    logic        EX_taken = 1'b0;
    logic [31:0] EX_target = 32'h0;
    logic        EX_pred_taken = 1'b0;
    logic [31:0] EX_pred_target = 32'h0;
    logic [5:0]  EX_pred_idx = 6'h0;
    logic        flush;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    branch_predictor #(
        .RESET_PC    (32'h0000_0000),
        .PHT_ENTRIES (64),
        .IDX_WIDTH   (6),
        .GHR_WIDTH   (6)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall            (stall),
        .btb_hit          (btb_hit),
        .btb_target       (btb_target),
        .btb_branch       (btb_branch),
        .btb_jump         (btb_jump),
        .IF_pc            (IF_pc),
        .IF_pred_taken    (IF_pred_taken),
        .IF_pred_target   (IF_pred_target),
        .IF_pred_idx      (IF_pred_idx),
        .EX_valid         (EX_valid),
        .EX_is_branch     (EX_is_branch),
        .EX_pc            (EX_pc),
        .EX_taken         (EX_taken),
        .EX_target        (EX_target),
        .EX_pred_taken    (EX_pred_taken),
        .EX_pred_target   (EX_pred_target),
        .EX_pred_idx      (EX_pred_idx),
        .flush            (flush),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: fetch PC, counters as integers 0..3, history as an
    // integer shifted left with the outcome appended, statistics counters.
    logic [31:0] m_pc;
    int          m_pht [64];
    int unsigned m_ghr;
    logic [31:0] m_bc;
    logic [31:0] m_mc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0;
        foreach (m_pht[i]) m_pht[i] = 1;
        m_ghr = 0;
        m_bc  = 32'h0;
        m_mc  = 32'h0;
    endtask

    // Called at posedge+1 with inputs already driven: checks all outputs
    // mid-cycle against the model, then advances model and DUT one clock.
    task automatic tick();
        int          idx;
        logic        pt;
        logic        fl;
        logic [31:0] tgt;
        logic [31:0] npc;
        #2;
        idx = int'(((m_pc >> 2) ^ 32'(m_ghr)) & 32'd63);
        pt  = btb_hit && (btb_jump || (btb_branch && m_pht[idx] >= 2));
        tgt = pt ? btb_target : m_pc + 32'd4;
        fl  = EX_valid && ((EX_taken != EX_pred_taken) ||
                           (EX_taken && (EX_target != EX_pred_target)));
        npc = fl ? (EX_taken ? EX_target : EX_pc + 32'd4) : (stall ? m_pc : tgt);
        chk("IF_pc", IF_pc, m_pc);
        chk("IF_pred_idx", 32'(IF_pred_idx), 32'(idx));
        chk("IF_pred_taken", 32'(IF_pred_taken), 32'(pt));
        chk("IF_pred_target", IF_pred_target, tgt);
        chk("flush", 32'(flush), 32'(fl));
        chk("branch_count", branch_count, m_bc);
        chk("mispredict_count", mispredict_count, m_mc);
        @(posedge clk);
        if (EX_valid && EX_is_branch) begin
            if (EX_taken) m_pht[EX_pred_idx] = (m_pht[EX_pred_idx] == 3) ? 3 : m_pht[EX_pred_idx] + 1;
            else          m_pht[EX_pred_idx] = (m_pht[EX_pred_idx] == 0) ? 0 : m_pht[EX_pred_idx] - 1;
            m_ghr = ((m_ghr << 1) | 32'(EX_taken)) & 32'd63;
            if (m_bc != 32'hFFFF_FFFF) m_bc = m_bc + 1;
        end
        if (fl && m_mc != 32'hFFFF_FFFF) m_mc = m_mc + 1;
        m_pc = npc;
        #1;
    endtask

    task automatic clear_ex();
        EX_valid = 1'b0; EX_is_branch = 1'b0; EX_pc = 32'h0; EX_taken = 1'b0;
        EX_target = 32'h0; EX_pred_taken = 1'b0; EX_pred_target = 32'h0; EX_pred_idx = 6'h0;
    endtask

    task automatic clear_btb();
        btb_hit = 1'b0; btb_branch = 1'b0; btb_jump = 1'b0; btb_target = 32'h0;
    endtask

    task automatic set_ex(input logic br, input logic [31:0] pc, input logic tk,
                          input logic [31:0] tgt, input logic ptk,
                          input logic [31:0] ptgt, input logic [5:0] pidx);
        EX_valid = 1'b1; EX_is_branch = br; EX_pc = pc; EX_taken = tk;
        EX_target = tgt; EX_pred_taken = ptk; EX_pred_target = ptgt; EX_pred_idx = pidx;
    endtask

    // Redirect fetch with a mispredicted jump (no PHT/GHR side effects).
    task automatic redirect(input logic [31:0] to);
        set_ex(1'b0, 32'h0000_0900, 1'b1, to, 1'b0, 32'h0000_0904, 6'd0);
        tick();
        clear_ex();
    endtask

    // Correctly predicted resolution of a branch that trains one PHT entry.
    task automatic resolve(input logic [5:0] idx, input logic tk);
        set_ex(1'b1, 32'h0000_0500, tk, 32'h0000_0600, tk, tk ? 32'h0000_0600 : 32'h0000_0504, idx);
        tick();
        clear_ex();
    endtask

    // Fetch a BTB-hit branch that lands on PHT entry idx and check its direction.
    task automatic probe(input logic [5:0] idx, input logic exp_taken, input string tag);
        redirect(((32'(idx) ^ 32'(m_ghr)) & 32'd63) << 2);
        btb_hit = 1'b1; btb_branch = 1'b1; btb_target = 32'h0000_0700;
        #1;
        chk(tag, 32'(IF_pred_taken), 32'(exp_taken));
        tick();
        clear_btb();
    endtask

    initial begin
        logic [31:0] r;

        // Reset and sequential fetch
        model_reset();
        #1 rst_n = 1'b0;
        #2;
        chk("rst_pc", IF_pc, 32'h0);
        chk("rst_flush", 32'(flush), 32'h0);
        chk("rst_bc", branch_count, 32'h0);
        chk("rst_mc", mispredict_count, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("seq_pc", IF_pc, 32'(4 * i));
            tick();
        end
        for (int g = 0; g < 40 && m_pc != 32'h40; g++) tick();
        chk("reach_40", IF_pc, 32'h40);

        // BTB jump and stall hold
        btb_hit = 1'b1; btb_jump = 1'b1; btb_target = 32'h100;
        #1 chk("jump_pred", 32'(IF_pred_taken), 32'h1);
        tick();
        clear_btb();
        chk("jump_pc", IF_pc, 32'h100);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_hold", IF_pc, 32'h100);
        end
        stall = 1'b0;
        tick();
        chk("stall_release", IF_pc, 32'h104);

        // Branch at 0x20 predicted not-taken, resolved taken
        redirect(32'h20);
        chk("redir_pc", IF_pc, 32'h20);
        btb_hit = 1'b1; btb_branch = 1'b1; btb_target = 32'h80;
        #1;
        chk("br_pred_nt", 32'(IF_pred_taken), 32'h0);
        chk("br_idx", 32'(IF_pred_idx), 32'h8);
        tick();
        clear_btb();
        set_ex(1'b1, 32'h20, 1'b1, 32'h80, 1'b0, 32'h24, 6'd8);
        #1 chk("br_flush", 32'(flush), 32'h1);
        tick();
        clear_ex();
        chk("br_redirect", IF_pc, 32'h80);
        chk("br_bc", branch_count, 32'h1);
        chk("br_mc", mispredict_count, 32'h2);
        set_ex(1'b1, 32'h20, 1'b1, 32'h80, 1'b1, 32'h80, 6'd8);
        #1 chk("br_no_flush", 32'(flush), 32'h0);
        tick();
        clear_ex();
        probe(6'd8, 1'b1, "pht8_taken");

        // Flush beats stall
        stall = 1'b1;
        set_ex(1'b1, 32'h30, 1'b0, 32'h99, 1'b1, 32'h80, 6'd8);
        tick();
        clear_ex();
        stall = 1'b0;
        chk("flush_over_stall", IF_pc, 32'h34);

        // Counter saturation on one entry
        resolve(6'd5, 1'b1); resolve(6'd5, 1'b1);
        probe(6'd5, 1'b1, "sat_2taken");
        resolve(6'd5, 1'b1); resolve(6'd5, 1'b1);
        resolve(6'd5, 1'b0);
        probe(6'd5, 1'b1, "sat_hi_hold");
        for (int i = 0; i < 4; i++) resolve(6'd5, 1'b0);
        probe(6'd5, 1'b0, "sat_lo");
        resolve(6'd5, 1'b1);
        probe(6'd5, 1'b0, "sat_lo_hold");

        // PC+4 wraps at the top of the address space
        redirect(32'hFFFF_FFFC);
        #1 chk("wrap_target", IF_pred_target, 32'h0);
        tick();
        chk("wrap_pc", IF_pc, 32'h0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            stall      = ($urandom_range(0, 3) == 0);
            btb_hit    = 1'($urandom_range(0, 1));
            btb_branch = 1'($urandom_range(0, 1));
            btb_jump   = ($urandom_range(0, 3) == 0);
            btb_target = 32'($urandom_range(0, 255)) << 2;
            EX_valid   = 1'($urandom_range(0, 1));
            EX_is_branch = ($urandom_range(0, 3) != 0);
            EX_taken   = EX_is_branch ? 1'($urandom_range(0, 1)) : 1'b1;
            EX_pc      = 32'($urandom_range(0, 255)) << 2;
            EX_target  = 32'($urandom_range(0, 255)) << 2;
            EX_pred_taken = ($urandom_range(0, 3) != 0) ? EX_taken : ~EX_taken;
            r = 32'($urandom_range(0, 255)) << 2;
            EX_pred_target = ($urandom_range(0, 3) != 0) ? EX_target : r;
            EX_pred_idx = 6'($urandom_range(0, 63));
            tick();
        end

        // Asynchronous reset mid-run with a mispredict pending
        set_ex(1'b1, 32'h40, 1'b1, 32'h200, 1'b0, 32'h44, 6'd3);
        stall = 1'b0;
        clear_btb();
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_pc", IF_pc, 32'h0);
        chk("mid_rst_flush", 32'(flush), 32'h0);
        chk("mid_rst_bc", branch_count, 32'h0);
        chk("mid_rst_mc", mispredict_count, 32'h0);
        model_reset();
        @(posedge clk); #3;
        chk("mid_rst_hold", IF_pc, 32'h0);
        rst_n = 1'b1;
        clear_ex();

        // Every PHT entry must be back to weakly not-taken
        btb_hit = 1'b1; btb_branch = 1'b1; btb_target = 32'h300;
        for (int i = 0; i < 64; i++) begin
            chk("pht_reset_nt", 32'(IF_pred_taken), 32'h0);
            tick();
        end
        clear_btb();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute time limit so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule : tb_branch_predictor
